regfile_wb_ctrl: RTL and testbench
==================================

// Module: regfile_wb_ctrl
// PURPOSE
// - Writeback controller driving the three write ports of the 16x32 register file.
// - Accepts writeback requests from three producers over independent valid/ready
//   channels (ch0 ALU result, ch1 load data, ch2 base-address update).
// - Buffers each channel, issues up to 3 writes per cycle in program order,
//   and publishes a per-register pending mask for the hazard unit.
// PARAMETERS
// - DEPTH  4  entries per channel FIFO (power of two, >=2)
// - SEQ_W  5  age-tag width; must satisfy 3*DEPTH < 2**(SEQ_W-1)
// PORTS
// - clk                     in   1   clock; all state updates on posedge
// - rst                     in   1   synchronous reset, active-high
// - in_valid[k], k=0..2     in   1   channel k request valid
// - in_ready[k]             out  1   channel k can accept (FIFO not full)
// - in_addr[k]              in   4   destination register R0..R15
// - in_data[k]              in   32  writeback value
// - w_en1/w_addr1/w_data1   out  1/4/32  regfile write port 1 (from ch0 FIFO head)
// - w_en2/w_addr2/w_data2   out  1/4/32  regfile write port 2 (from ch1 FIFO head)
// - w_en3/w_addr3/w_data3   out  1/4/32  regfile write port 3 (from ch2 FIFO head)
// - pending                 out  16  bit r set while any queued write targets Rr
// - idle                    out  1   all FIFOs empty
// BEHAVIOUR
// - Clock is clk; reset rst is synchronous, active-high.
// - Reset: FIFOs flushed, tag counter=0, pending=0, idle=1, in_ready=0 during the
//   reset cycle, all w_en*=0, w_addr*=0, w_data*=0. Reset mid-operation drops
//   queued writes; no write is issued in the reset cycle.
// - Accept: in_valid[k]&&in_ready[k] at edge N enqueues {addr,data,tag}.
//   in_ready[k] = !full[k]; enqueue while full is ignored (no overwrite).
// - Tags: global counter; same-cycle accepts ordered ch0<ch1<ch2, each consuming
//   one tag; counter advances by number accepted, wraps mod 2**SEQ_W; age compare
//   uses wrap-aware subtraction.
// - Issue: each cycle, head of each non-empty FIFO is a candidate. Candidate k
//   issues (w_en=1, outputs from head, popped at edge) unless an older candidate
//   (smaller tag) targets the same addr; then k stalls, outputs w_en=0, addr/data 0.
//   Guarantees no two write ports carry the same addr in one cycle.
// - Outputs are combinational from FIFO heads; latency accept->regfile write =
//   1 cycle minimum (accepted at edge N, w_en high cycle N..N+1, written edge N+1).
// - Same-cycle enqueue and dequeue on a full FIFO: dequeue frees slot only from
//   next cycle; in_ready stays 0 that cycle.
// - pending: per-register counter of queued entries (width clog2(3*DEPTH+1));
//   increments on accept, decrements on issue, both same cycle = unchanged;
//   pending[r] = (count[r]!=0). Reflects state after edge (registered).
// - R15 writes handled like any register; no special PC behaviour.
// CONFIGURATION
// - REGFILE_WB_BYPASS_EN defined: when channel k FIFO is empty, in_valid[k] is
//   not stalled by collision with an older head, and in_ready[k]=1, the request
//   drives write port k combinationally and is not enqueued: written at edge N
//   (0-cycle latency); tag still consumed; pending unaffected.
// - Undefined: every request passes through the FIFO (1-cycle minimum latency).
// TESTING
// - Reset then ch0 R3<=0x11 at cycle 1 -> w_en1=1,w_addr1=3,w_data1=0x11 in
//   cycle 2 (cycle 1 with BYPASS); pending[3]=1 for one cycle only (no BYPASS).
// - Same cycle ch0 R5<=0xA, ch2 R5<=0xB -> cycle+1: port1 writes 0xA, port3 idle;
//   cycle+2: port3 writes 0xB; final R5=0xB; pending[5] clears after cycle+2.
// - Fill ch1 with DEPTH writes while port 1 collides every cycle -> in_ready[1]=0
//   after DEPTH accepts; extra valid ignored; drains in order once released.
// - ch0 R1, ch1 R2, ch2 R4 same cycle -> all three w_en high next cycle, idle=1 after.
// - Run 2**SEQ_W+3 accepted writes to one register across channels -> tag wrap
//   preserves order; final value = last accepted.
// - Assert rst with 3 entries queued -> next cycle all w_en=0, pending=0, idle=1.

Source files
------------

// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle for the register-file writeback controller: three producer
// valid/ready channels, three regfile write ports, and the pending/idle status.
interface regfile_wb_ctrl_if;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [3:0]  in_addr [3];
  logic [31:0] in_data [3];

  logic        w_en1, w_en2, w_en3;
  logic [3:0]  w_addr1, w_addr2, w_addr3;
  logic [31:0] w_data1, w_data2, w_data3;

  logic [15:0] pending;
  logic        idle;

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready,
    input  w_en1, w_en2, w_en3, w_addr1, w_addr2, w_addr3,
    input  w_data1, w_data2, w_data3, pending, idle
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready,
    output w_en1, w_en2, w_en3, w_addr1, w_addr2, w_addr3,
    output w_data1, w_data2, w_data3, pending, idle
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: three tagged per-channel FIFOs feeding the three regfile
// write ports in program order. Optional REGFILE_WB_BYPASS_EN adds 0-cycle bypass.
module regfile_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  regfile_wb_ctrl_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PC_W  = $clog2(3*DEPTH + 1);

  typedef struct packed {
    logic [3:0]       addr;
    logic [31:0]      data;
    logic [SEQ_W-1:0] tag;
  } entry_t;

  entry_t           fifo_q   [3][DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [3];
  logic [PTR_W-1:0] wr_ptr_q [3];
  logic [CNT_W-1:0] cnt_q    [3];
  logic [SEQ_W-1:0] tag_q, tag_d;
  logic [PC_W-1:0]  pcnt_q   [16];
  logic [PC_W-1:0]  pcnt_d   [16];

  logic [2:0]       empty, ready, acc, cand_v, stall, issue, byp, pop, enq;
  logic [SEQ_W-1:0] new_tag  [3];
  entry_t           cand     [3];

  // a is older than b when the wrap-aware difference a-b is negative
  function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      empty[k] = (cnt_q[k] == '0);
      ready[k] = (cnt_q[k] != CNT_W'(DEPTH)) && !rst_i;
      acc[k]   = bus.in_valid[k] && ready[k];
    end
    new_tag[0] = tag_q;
    new_tag[1] = tag_q + SEQ_W'(acc[0]);
    new_tag[2] = tag_q + SEQ_W'(acc[0]) + SEQ_W'(acc[1]);
    tag_d      = tag_q + SEQ_W'(acc[0]) + SEQ_W'(acc[1]) + SEQ_W'(acc[2]);
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cand[k]   = fifo_q[k][rd_ptr_q[k]];
      cand_v[k] = !empty[k] && !rst_i;
`ifdef REGFILE_WB_BYPASS_EN
      // an empty channel offers its incoming request as the candidate
      if (empty[k] && acc[k]) begin
        cand[k]   = '{addr: bus.in_addr[k], data: bus.in_data[k], tag: new_tag[k]};
        cand_v[k] = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      stall[k] = 1'b0;
      for (int j = 0; j < 3; j++) begin
        if (j != k && cand_v[j] && cand_v[k] && cand[j].addr == cand[k].addr &&
            older(cand[j].tag, cand[k].tag))
          stall[k] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      issue[k] = cand_v[k] && !stall[k];
      byp[k]   = issue[k] && empty[k];
      pop[k]   = issue[k] && !empty[k];
      enq[k]   = acc[k] && !byp[k];
    end
  end

  always_comb begin
    logic [PC_W-1:0] inc, dec;
    for (int r = 0; r < 16; r++) begin
      inc = '0;
      dec = '0;
      for (int k = 0; k < 3; k++) begin
        if (enq[k] && bus.in_addr[k] == 4'(r)) inc = inc + PC_W'(1);
        if (pop[k] && cand[k].addr == 4'(r))   dec = dec + PC_W'(1);
      end
      pcnt_d[r] = pcnt_q[r] + inc - dec;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= '0;
      for (int k = 0; k < 3; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      for (int r = 0; r < 16; r++) pcnt_q[r] <= '0;
    end else begin
      tag_q <= tag_d;
      for (int k = 0; k < 3; k++) begin
        if (enq[k]) begin
          fifo_q[k][wr_ptr_q[k]] <= '{addr: bus.in_addr[k], data: bus.in_data[k], tag: new_tag[k]};
          wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        end
        if (pop[k]) rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        cnt_q[k] <= cnt_q[k] + CNT_W'(enq[k]) - CNT_W'(pop[k]);
      end
      for (int r = 0; r < 16; r++) pcnt_q[r] <= pcnt_d[r];
    end
  end

  always_comb begin
    bus.in_ready = ready;
    bus.w_en1    = issue[0];
    bus.w_addr1  = issue[0] ? cand[0].addr : '0;
    bus.w_data1  = issue[0] ? cand[0].data : '0;
    bus.w_en2    = issue[1];
    bus.w_addr2  = issue[1] ? cand[1].addr : '0;
    bus.w_data2  = issue[1] ? cand[1].data : '0;
    bus.w_en3    = issue[2];
    bus.w_addr3  = issue[2] ? cand[2].addr : '0;
    bus.w_data3  = issue[2] ? cand[2].data : '0;
    bus.idle     = empty[0] && empty[1] && empty[2];
    for (int r = 0; r < 16; r++) bus.pending[r] = (pcnt_q[r] != '0);
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl (default build, FIFO path only) with a
// behavioural register file attached to the three write ports.
module tb_regfile_wb_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  regfile_wb_ctrl_if bus ();
  regfile_wb_ctrl #(.DEPTH(4), .SEQ_W(5)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] rf [16];
  int r9_writes = 0;
  int r9_order_err = 0;

  initial for (int r = 0; r < 16; r++) rf[r] = '0;

  always @(posedge clk) begin
    logic        en [3];
    logic [3:0]  ad [3];
    logic [31:0] da [3];
    en[0] = bus.w_en1; ad[0] = bus.w_addr1; da[0] = bus.w_data1;
    en[1] = bus.w_en2; ad[1] = bus.w_addr2; da[1] = bus.w_data2;
    en[2] = bus.w_en3; ad[2] = bus.w_addr3; da[2] = bus.w_data3;
    for (int p = 0; p < 3; p++) begin
      if (en[p] === 1'b1) begin
        rf[ad[p]] <= da[p];
        if (ad[p] == 4'd9) begin
          if (da[p] != 32'h5000 + 32'(r9_writes)) r9_order_err++;
          r9_writes++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input int k, input logic [3:0] a, input logic [31:0] d);
    bus.in_valid[k] = 1'b1;
    bus.in_addr[k]  = a;
    bus.in_data[k]  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, guard;
    rst = 1'b1;
    bus.in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      bus.in_addr[k] = '0;
      bus.in_data[k] = '0;
    end

    // reset
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_w_en", {29'b0, bus.w_en1, bus.w_en2, bus.w_en3}, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_idle", 32'(bus.idle), 32'h1);
    chk("post_rst_pending", 32'(bus.pending), 32'h0);
    chk("post_rst_ready", 32'(bus.in_ready), 32'h7);
    chk("post_rst_waddr1", 32'(bus.w_addr1), 32'h0);

    // single write, 1-cycle latency
    req(0, 4'd3, 32'h11);
    tick();
    bus.in_valid = '0;
    chk("t1_w_en1", 32'(bus.w_en1), 32'h1);
    chk("t1_w_addr1", 32'(bus.w_addr1), 32'h3);
    chk("t1_w_data1", bus.w_data1, 32'h11);
    chk("t1_pending", 32'(bus.pending), 32'h0008);
    tick();
    chk("t1_w_en1_off", 32'(bus.w_en1), 32'h0);
    chk("t1_pending_clr", 32'(bus.pending), 32'h0);
    chk("t1_idle", 32'(bus.idle), 32'h1);
    chk("t1_rf3", rf[3], 32'h11);

    // same-address collision ch0 vs ch2
    req(0, 4'd5, 32'hA);
    req(2, 4'd5, 32'hB);
    tick();
    bus.in_valid = '0;
    chk("t2_c1_w_en1", 32'(bus.w_en1), 32'h1);
    chk("t2_c1_w_data1", bus.w_data1, 32'hA);
    chk("t2_c1_w_en3", 32'(bus.w_en3), 32'h0);
    chk("t2_c1_w_addr3", 32'(bus.w_addr3), 32'h0);
    chk("t2_c1_pending", 32'(bus.pending), 32'h0020);
    tick();
    chk("t2_c2_w_en1", 32'(bus.w_en1), 32'h0);
    chk("t2_c2_w_en3", 32'(bus.w_en3), 32'h1);
    chk("t2_c2_w_addr3", 32'(bus.w_addr3), 32'h5);
    chk("t2_c2_w_data3", bus.w_data3, 32'hB);
    chk("t2_c2_pending", 32'(bus.pending), 32'h0020);
    tick();
    chk("t2_pending_clr", 32'(bus.pending), 32'h0);
    chk("t2_rf5", rf[5], 32'hB);

    // ch1 fills while older R7 backlog in ch0/ch2 keeps it stalled
    for (int i = 0; i < 4; i++) begin
      req(0, 4'd7, 32'h100 + 32'(2*i));
      req(2, 4'd7, 32'h101 + 32'(2*i));
      tick();
    end
    bus.in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      req(1, 4'd7, 32'h200 + 32'(i));
      chk("t3_ready1_fill", 32'(bus.in_ready[1]), 32'h1);
      if (i == 1) begin
        chk("t3_stall_w_en2", 32'(bus.w_en2), 32'h0);
        chk("t3_stall_w_en1", 32'(bus.w_en1), 32'h1);
      end
      tick();
    end
    req(1, 4'd7, 32'hDEAD);
    chk("t3_full_ready1", 32'(bus.in_ready[1]), 32'h0);
    chk("t3_full_w_en2", 32'(bus.w_en2), 32'h0);
    tick();
    chk("t3_full_ready1_b", 32'(bus.in_ready[1]), 32'h0);
    bus.in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      chk("t3_drain_w_en2", 32'(bus.w_en2), 32'h1);
      chk("t3_drain_w_data2", bus.w_data2, 32'h200 + 32'(i));
    end
    tick();
    chk("t3_w_en2_off", 32'(bus.w_en2), 32'h0);
    chk("t3_idle", 32'(bus.idle), 32'h1);
    chk("t3_rf7", rf[7], 32'h203);

    // three distinct addresses issue in parallel
    req(0, 4'd1, 32'h1);
    req(1, 4'd2, 32'h2);
    req(2, 4'd4, 32'h4);
    tick();
    bus.in_valid = '0;
    chk("t4_w_en_all", {29'b0, bus.w_en1, bus.w_en2, bus.w_en3}, 32'h7);
    chk("t4_addrs", {20'b0, bus.w_addr1, bus.w_addr2, bus.w_addr3}, 32'h124);
    chk("t4_pending", 32'(bus.pending), 32'h0016);
    tick();
    chk("t4_idle", 32'(bus.idle), 32'h1);
    chk("t4_pending_clr", 32'(bus.pending), 32'h0);
    chk("t4_rf", rf[1] + rf[2] + rf[4], 32'h7);

    // 35 ordered writes to R9 across all channels, spanning a tag wrap
    n = 0;
    guard = 0;
    while (n < 35 && guard < 300) begin
      for (int k = 0; k < 3; k++) begin
        if (bus.in_ready[k] && n < 35) begin
          req(k, 4'd9, 32'h5000 + 32'(n));
          n++;
        end else begin
          bus.in_valid[k] = 1'b0;
        end
      end
      tick();
      guard++;
    end
    bus.in_valid = '0;
    for (int i = 0; i < 100; i++) begin
      if (bus.idle) break;
      tick();
    end
    chk("t5_sent", 32'(n), 32'd35);
    chk("t5_idle", 32'(bus.idle), 32'h1);
    chk("t5_writes", 32'(r9_writes), 32'd35);
    chk("t5_order_err", 32'(r9_order_err), 32'd0);
    chk("t5_rf9", rf[9], 32'h5022);

    // reset with three queued entries
    req(0, 4'd6, 32'h61);
    req(1, 4'd6, 32'h62);
    req(2, 4'd6, 32'h63);
    tick();
    bus.in_valid = '0;
    rst = 1'b1;
    #1;
    chk("t6_rst_w_en", {29'b0, bus.w_en1, bus.w_en2, bus.w_en3}, 32'h0);
    chk("t6_rst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("t6_w_en", {29'b0, bus.w_en1, bus.w_en2, bus.w_en3}, 32'h0);
    chk("t6_pending", 32'(bus.pending), 32'h0);
    chk("t6_idle", 32'(bus.idle), 32'h1);
    chk("t6_rf6", rf[6], 32'h0);
    tick();
    chk("t6_idle_b", 32'(bus.idle), 32'h1);
    chk("t6_rf6_b", rf[6], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
